// File: rtl/rominit_sink.sv
// ROMINIT stream receiver: boot/CHR direct BRAM writes, cart bytes via FIFO to a req/ack port.
// Optional ROMINIT_CART_CHECKSUM_EN adds CART_SUM, the 16-bit byte sum of the last cart session.
module rominit_sink #(
  parameter int BOOT_AW    = 12,
  parameter int CHR_AW     = 10,
  parameter int CART_AW    = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 ROMINIT_SEL_BOOT,
  input  logic                 ROMINIT_SEL_CHR,
  input  logic                 ROMINIT_SEL_CART,
  input  logic [24:0]          ROMINIT_ADDR,
  input  logic [7:0]           ROMINIT_DATA,
  input  logic                 ROMINIT_VALID,
  output logic                 BOOT_WE,
  output logic [BOOT_AW-1:0]   BOOT_A,
  output logic [7:0]           BOOT_D,
  output logic                 CHR_WE,
  output logic [CHR_AW-1:0]    CHR_A,
  output logic [7:0]           CHR_D,
  output logic                 CART_REQ,
  output logic [CART_AW-1:0]   CART_A,
  output logic [7:0]           CART_D,
  input  logic                 CART_ACK,
  output logic [CART_AW:0]     CART_SIZE,
  output logic                 CART_SIZE_VALID,
`ifdef ROMINIT_CART_CHECKSUM_EN
  output logic [15:0]          CART_SUM,
`endif
  output logic                 BUSY,
  output logic                 ERR
);

  // state   | meaning
  // S_IDLE  | no session, waiting for a selected byte
  // S_LOAD  | stream active, at least one select high
  // S_DRAIN | selects low, cart FIFO emptying
  // S_DONE  | one cycle: publish cart size if the session hit cart
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);

  state_t state_q, state_d;

  logic any_sel, multi_sel, eff_cart;
  logic in_boot, in_chr, in_cart;
  logic acc_boot, acc_chr, acc_cart, cart_start;

  logic               boot_we_q, chr_we_q;
  logic [BOOT_AW-1:0] boot_a_q;
  logic [CHR_AW-1:0]  chr_a_q;
  logic [7:0]         boot_d_q, chr_d_q;

  logic               push_q;
  logic [CART_AW-1:0] push_a_q;
  logic [7:0]         push_d_q;
  logic [CART_AW:0]   push_end;

  logic [CART_AW+7:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, rd_q;
  logic [PW:0]        cnt_q;
  logic               empty, full, pop, wr_en, ovf;

  logic               cart_sess_q, size_vld_q, err_q;
  logic [CART_AW:0]   size_max_q, size_q;

  assign any_sel   = ROMINIT_SEL_BOOT | ROMINIT_SEL_CHR | ROMINIT_SEL_CART;
  assign multi_sel = (ROMINIT_SEL_BOOT & ROMINIT_SEL_CHR) | (ROMINIT_SEL_BOOT & ROMINIT_SEL_CART)
                   | (ROMINIT_SEL_CHR & ROMINIT_SEL_CART);
  assign eff_cart  = ROMINIT_SEL_CART & ~ROMINIT_SEL_BOOT & ~ROMINIT_SEL_CHR;

  assign in_boot = (ROMINIT_ADDR >> BOOT_AW) == '0;
  assign in_chr  = (ROMINIT_ADDR >> CHR_AW) == '0;
  assign in_cart = (ROMINIT_ADDR >> CART_AW) == '0;

  assign acc_boot = ROMINIT_VALID & ROMINIT_SEL_BOOT & in_boot;
  assign acc_chr  = ROMINIT_VALID & ~ROMINIT_SEL_BOOT & ROMINIT_SEL_CHR & in_chr;
  assign acc_cart = ROMINIT_VALID & eff_cart & in_cart;

  // First cart byte of a session restarts the size/sum accumulation.
  assign cart_start = ROMINIT_VALID & eff_cart & ~cart_sess_q
                    & ((state_q == S_IDLE) || (state_q == S_LOAD));

  always_ff @(posedge CLK) begin
    if (RES) begin
      boot_we_q <= 1'b0;
      boot_a_q  <= '0;
      boot_d_q  <= '0;
      chr_we_q  <= 1'b0;
      chr_a_q   <= '0;
      chr_d_q   <= '0;
      push_q    <= 1'b0;
      push_a_q  <= '0;
      push_d_q  <= '0;
    end else begin
      boot_we_q <= acc_boot;
      chr_we_q  <= acc_chr;
      push_q    <= acc_cart;
      if (acc_boot) begin
        boot_a_q <= ROMINIT_ADDR[BOOT_AW-1:0];
        boot_d_q <= ROMINIT_DATA;
      end
      if (acc_chr) begin
        chr_a_q <= ROMINIT_ADDR[CHR_AW-1:0];
        chr_d_q <= ROMINIT_DATA;
      end
      if (acc_cart) begin
        push_a_q <= ROMINIT_ADDR[CART_AW-1:0];
        push_d_q <= ROMINIT_DATA;
      end
    end
  end

  assign BOOT_WE = boot_we_q;
  assign BOOT_A  = boot_a_q;
  assign BOOT_D  = boot_d_q;
  assign CHR_WE  = chr_we_q;
  assign CHR_A   = chr_a_q;
  assign CHR_D   = chr_d_q;

  // A push into a full FIFO is fine when the head pops on the same edge.
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop      = CART_ACK & ~empty;
  assign wr_en    = push_q & (~full | pop);
  assign ovf      = push_q & full & ~pop;
  assign push_end = {1'b0, push_a_q} + (CART_AW+1)'(1);

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_q] <= {push_a_q, push_d_q};
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ROMINIT_VALID && any_sel) state_d = S_LOAD;
      S_LOAD:  if (!any_sel) state_d = S_DRAIN;
      S_DRAIN: if (empty && !push_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state_q == S_LOAD) || (state_q == S_DRAIN);
    CART_REQ = ~empty;
    CART_A   = '0;
    CART_D   = '0;
    if (!empty) {CART_A, CART_D} = mem_q[rd_q];
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      cart_sess_q <= 1'b0;
      size_max_q  <= '0;
      size_q      <= '0;
      size_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_q | (ROMINIT_VALID & multi_sel) | ovf;
      if (cart_start) begin
        cart_sess_q <= 1'b1;
        size_vld_q  <= 1'b0;
        size_max_q  <= '0;
      end else begin
        if (wr_en && (push_end > size_max_q)) size_max_q <= push_end;
        if (state_q == S_DONE) begin
          cart_sess_q <= 1'b0;
          if (cart_sess_q) begin
            size_q     <= size_max_q;
            size_vld_q <= 1'b1;
          end
        end
      end
    end
  end

  assign CART_SIZE       = size_q;
  assign CART_SIZE_VALID = size_vld_q;
  assign ERR             = err_q;

`ifdef ROMINIT_CART_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge CLK) begin
    if (RES)             sum_q <= '0;
    else if (cart_start) sum_q <= '0;
    else if (wr_en)      sum_q <= sum_q + {8'h00, push_d_q};
  end

  assign CART_SUM = sum_q;
`endif

endmodule

// File: tb/tb_rominit_sink.sv
// Directed bench for rominit_sink: scoreboard queues filled at stimulus, drained by a monitor.
module tb_rominit_sink;

  logic        CLK, RES;
  logic        ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic        BOOT_WE, CHR_WE, CART_REQ, CART_ACK, CART_SIZE_VALID, BUSY, ERR;
  logic [11:0] BOOT_A;
  logic [9:0]  CHR_A;
  logic [16:0] CART_A;
  logic [7:0]  BOOT_D, CHR_D, CART_D;
  logic [17:0] CART_SIZE;
`ifdef ROMINIT_CART_CHECKSUM_EN
  logic [15:0] CART_SUM;
`endif

  rominit_sink dut (
    .CLK(CLK), .RES(RES),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_SEL_CART(ROMINIT_SEL_CART), .ROMINIT_ADDR(ROMINIT_ADDR),
    .ROMINIT_DATA(ROMINIT_DATA), .ROMINIT_VALID(ROMINIT_VALID),
    .BOOT_WE(BOOT_WE), .BOOT_A(BOOT_A), .BOOT_D(BOOT_D),
    .CHR_WE(CHR_WE), .CHR_A(CHR_A), .CHR_D(CHR_D),
    .CART_REQ(CART_REQ), .CART_A(CART_A), .CART_D(CART_D), .CART_ACK(CART_ACK),
    .CART_SIZE(CART_SIZE), .CART_SIZE_VALID(CART_SIZE_VALID),
`ifdef ROMINIT_CART_CHECKSUM_EN
    .CART_SUM(CART_SUM),
`endif
    .BUSY(BUSY), .ERR(ERR)
  );

  typedef struct { logic [11:0] a; logic [7:0] d; int cyc; } wr_t;
  typedef struct { logic [16:0] a; logic [7:0] d; } ct_t;

  wr_t boot_q[$], chr_q[$], mon_w;
  ct_t cart_q[$], mon_c;

  int checks = 0, failures = 0;
  int cyc = 0, boot_seen = 0, hs_count = 0, last_a = -1;
  int ack_mode = 1, wait_cnt = 0;
  bit cart_strict = 1;
  bit prev_req = 0, prev_hs = 0, hs;
  logic [24:0] prev_ad;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ACK responder: 0 = never, 1 = always high, 2 = two-cycle wait then a one-cycle ack.
  always @(posedge CLK) begin
    #1;
    if (ack_mode == 0) CART_ACK = 1'b0;
    else if (ack_mode == 1) CART_ACK = 1'b1;
    else if (CART_ACK) begin
      CART_ACK = 1'b0;
      wait_cnt = 0;
    end else if (CART_REQ) begin
      wait_cnt++;
      if (wait_cnt >= 2) CART_ACK = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (BOOT_WE) begin
      boot_seen++;
      if (boot_q.size() == 0) check("boot_unexpected_we", BOOT_WE, 0);
      else begin
        mon_w = boot_q.pop_front();
        check("boot_a", BOOT_A, mon_w.a);
        check("boot_d", BOOT_D, mon_w.d);
        check("boot_latency", cyc, mon_w.cyc);
      end
    end
    if (CHR_WE) begin
      if (chr_q.size() == 0) check("chr_unexpected_we", CHR_WE, 0);
      else begin
        mon_w = chr_q.pop_front();
        check("chr_a", CHR_A, mon_w.a);
        check("chr_d", CHR_D, mon_w.d);
        check("chr_latency", cyc, mon_w.cyc);
      end
    end
    hs = CART_REQ && CART_ACK;
    if (hs) begin
      hs_count++;
      if (cart_strict) begin
        if (cart_q.size() == 0) check("cart_unexpected_write", CART_REQ, 0);
        else begin
          mon_c = cart_q.pop_front();
          check("cart_a", CART_A, mon_c.a);
          check("cart_d", CART_D, mon_c.d);
        end
      end else begin
        check("cart_order", int'(CART_A) > last_a, 1);
        check("cart_d_pattern", CART_D, CART_A[7:0] ^ 8'hA5);
        last_a = int'(CART_A);
      end
    end
    if (CART_REQ && prev_req && !prev_hs) check("cart_hold", {CART_A, CART_D}, prev_ad);
    prev_req = CART_REQ;
    prev_hs  = hs;
    prev_ad  = {CART_A, CART_D};
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic b, input logic c, input logic k,
                      input logic [24:0] a, input logic [7:0] d);
    wr_t w;
    ct_t x;
    ROMINIT_SEL_BOOT = b;
    ROMINIT_SEL_CHR  = c;
    ROMINIT_SEL_CART = k;
    ROMINIT_ADDR     = a;
    ROMINIT_DATA     = d;
    ROMINIT_VALID    = 1'b1;
    w.a = a[11:0]; w.d = d; w.cyc = cyc + 1;
    x.a = a[16:0]; x.d = d;
    if (b) begin
      if (a < 25'd4096) boot_q.push_back(w);
    end else if (c) begin
      if (a < 25'd1024) chr_q.push_back(w);
    end else if (k && cart_strict && a < 25'h20000) cart_q.push_back(x);
    tick();
    ROMINIT_VALID = 1'b0;
  endtask

  task automatic end_session();
    ROMINIT_SEL_BOOT = 1'b0;
    ROMINIT_SEL_CHR  = 1'b0;
    ROMINIT_SEL_CART = 1'b0;
    ROMINIT_VALID    = 1'b0;
    tick();
    for (int i = 0; i < 200 && BUSY; i++) tick();
    check("busy_timeout", BUSY, 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    RES = 1'b1;
    tick();
    RES = 1'b0;
    tick();
  endtask

  initial begin
    RES = 1'b1;
    CART_ACK = 1'b0;
    ROMINIT_SEL_BOOT = 0; ROMINIT_SEL_CHR = 0; ROMINIT_SEL_CART = 0;
    ROMINIT_ADDR = '0; ROMINIT_DATA = '0; ROMINIT_VALID = 0;
    tick();
    tick();
    check("rst_boot_we", BOOT_WE, 0);
    check("rst_chr_we", CHR_WE, 0);
    check("rst_cart_req", CART_REQ, 0);
    check("rst_cart_size", CART_SIZE, 0);
    check("rst_size_valid", CART_SIZE_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    RES = 1'b0;
    tick();

    // Boot load: 4096 back-to-back bytes
    for (int i = 0; i < 4096; i++) send(1, 0, 0, 25'(i), 8'(i));
    check("boot_busy", BUSY, 1);
    end_session();
    check("boot_count", boot_seen, 4096);
    check("boot_q_drained", boot_q.size(), 0);
    check("boot_last_a", BOOT_A, 12'hFFF);
    check("boot_last_d", BOOT_D, 8'hFF);

    // Cart, 2-cycle ack, 3-cycle gaps: all 8 in order
    ack_mode = 2; cart_strict = 1; hs_count = 0;
    for (int i = 0; i < 8; i++) begin
      send(0, 0, 1, 25'(i), 8'(i) ^ 8'hA5);
      repeat (3) tick();
    end
    end_session();
    check("gap_all_written", hs_count, 8);
    check("gap_q_drained", cart_q.size(), 0);
    check("gap_err", ERR, 0);

    // Cart size 0x8000 with immediate ack
    ack_mode = 1;
    for (int i = 0; i < 32'h8000; i++) send(0, 0, 1, 25'(i), 8'(i) ^ 8'hA5);
    end_session();
    check("size_q_drained", cart_q.size(), 0);
    check("cart_size", CART_SIZE, 18'h08000);
    check("cart_size_valid", CART_SIZE_VALID, 1);

    // CHR session incl. out-of-range 0x400; cart size must stay put
    send(0, 1, 0, 25'h000, 8'h5C);
    send(0, 1, 0, 25'h400, 8'h11);
    send(0, 1, 0, 25'h3FF, 8'h22);
    end_session();
    check("chr_q_drained", chr_q.size(), 0);
    check("chr_cart_size_kept", CART_SIZE, 18'h08000);
    check("chr_size_valid_kept", CART_SIZE_VALID, 1);
    check("oor_err", ERR, 0);

    // Boot and cart selected together
    send(1, 0, 1, 25'h010, 8'h33);
    end_session();
    check("multi_boot_q_drained", boot_q.size(), 0);
    check("multi_err", ERR, 1);
    repeat (5) tick();
    check("multi_err_sticky", ERR, 1);
    do_reset();
    check("multi_err_cleared", ERR, 0);

    // Overflow: 8 bytes at one per cycle against a slow ack
    ack_mode = 2; cart_strict = 0; hs_count = 0; last_a = -1;
    for (int i = 0; i < 8; i++) send(0, 0, 1, 25'(i), 8'(i) ^ 8'hA5);
    end_session();
    check("ovf_err", ERR, 1);
    check("ovf_fewer_than_8", hs_count < 8, 1);
    check("ovf_some_written", hs_count > 0, 1);

`ifdef ROMINIT_CART_CHECKSUM_EN
    ack_mode = 1; cart_strict = 1;
    for (int i = 0; i < 300; i++) send(0, 0, 1, 25'(i), 8'hFF);
    end_session();
    check("sum_value", CART_SUM, 16'h2AD4);
    check("sum_size", CART_SIZE, 18'd300);
    check("sum_size_valid", CART_SIZE_VALID, 1);
`endif

    // Reset while draining with 3 queued entries
    ack_mode = 0; cart_strict = 0;
    tick();
    for (int i = 0; i < 3; i++) send(0, 0, 1, 25'(16 + i), 8'(16 + i) ^ 8'hA5);
    ROMINIT_SEL_CART = 1'b0;
    tick();
    check("mid_req_high", CART_REQ, 1);
    check("mid_busy_high", BUSY, 1);
    RES = 1'b1;
    tick();
    check("mid_req", CART_REQ, 0);
    check("mid_busy", BUSY, 0);
    check("mid_err", ERR, 0);
    check("mid_size_valid", CART_SIZE_VALID, 0);
    check("mid_size", CART_SIZE, 0);
    check("mid_cart_a", CART_A, 0);
    check("mid_cart_d", CART_D, 0);
    check("mid_boot_we", BOOT_WE, 0);
    check("mid_chr_we", CHR_WE, 0);
    RES = 1'b0;
    repeat (3) tick();
    check("mid_req_stays_low", CART_REQ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rominit_sink.md
Name: rominit_sink

Overview:
- Receiving end of the ROMINIT byte stream inside `scv`.
- Decodes the per-region select lines and writes the boot ROM and CHR ROM directly through internal BRAM write ports.
- Buffers cart bytes through a small FIFO to a req/ack memory port, since the stream has no backpressure.
- On completion of a cart load, reports the cart size to the mapper-auto logic.

Parameters:
- BOOT_AW, 12, boot ROM address width (4 KiB).
- CHR_AW, 10, CHR ROM address width (1 KiB).
- CART_AW, 17, cart address width (128 KiB max).
- FIFO_DEPTH, 4, cart write FIFO entries; power of 2, minimum 2.

Ports:
- CLK  in  1  system clock.
- RES  in  1  synchronous reset, active-high.
- ROMINIT_SEL_BOOT  in  1  stream targets boot ROM.
- ROMINIT_SEL_CHR  in  1  stream targets CHR ROM.
- ROMINIT_SEL_CART  in  1  stream targets cart ROM.
- ROMINIT_ADDR  in  25  byte address.
- ROMINIT_DATA  in  8  byte data.
- ROMINIT_VALID  in  1  byte present this cycle; no backpressure.
- BOOT_WE  out  1  boot ROM write strobe.
- BOOT_A  out  BOOT_AW  boot write address.
- BOOT_D  out  8  boot write data.
- CHR_WE  out  1  CHR write strobe.
- CHR_A  out  CHR_AW  CHR write address.
- CHR_D  out  8  CHR write data.
- CART_REQ  out  1  cart write request.
- CART_A  out  CART_AW  cart write address.
- CART_D  out  8  cart write data.
- CART_ACK  in  1  cart write accepted.
- CART_SIZE  out  CART_AW+1  highest written cart address + 1.
- CART_SIZE_VALID  out  1  CART_SIZE is valid.
- BUSY  out  1  load session active or FIFO draining.
- ERR  out  1  sticky error: overflow or multiple selects.

Behaviour:
- Clock and reset: single clock CLK. RES is synchronous and active-high.
- Reset values: all outputs 0, FIFO empty, state IDLE, size max 0.
- Reset mid-operation: abandons the session, deasserts CART_REQ on the next edge, and drops queued bytes.
- Region select: sampled every cycle with VALID=1.
  - Priority is BOOT > CHR > CART.
  - Two or more selects high sets ERR; the priority target still receives the byte.
  - No select high: byte dropped silently.
- Address range: an address at or beyond the target's depth (ADDR[24:AW] != 0) is dropped with no error.
- Boot/CHR writes: registered, 1-cycle latency.
  - WE pulses for exactly one cycle per accepted byte; A and D are valid in that cycle.
  - Back-to-back bytes produce back-to-back WE.
- Cart writes:
  - An accepted byte is pushed {addr, data} into the FIFO in the cycle after VALID.
  - Pop side: CART_REQ rises with A and D from the FIFO head.
  - A and D are held stable until CART_ACK is sampled high. The head pops on that edge.
  - CART_REQ may stay high if more entries remain; the next entry appears the cycle after the ack.
  - An ACK arriving while REQ=0 is ignored.
- FIFO boundary:
  - Push and pop in the same cycle are legal when full: the count is unchanged and no overflow.
  - Push while full without a pop: byte dropped, ERR set.
- Size tracking: a running max of (accepted cart addr + 1), width CART_AW+1, so a full 128 KiB cart reports 0x20000.
- State machine:
  - IDLE -> LOAD on VALID=1 with any select. BUSY=1 in LOAD. CART_SIZE_VALID clears if SEL_CART is set.
  - LOAD -> DRAIN when all three selects go low.
  - DRAIN -> DONE when the FIFO is empty and REQ=0.
  - DONE: if the session targeted cart, CART_SIZE updates and CART_SIZE_VALID sets. Returns to IDLE the next cycle.
  - BUSY=1 in LOAD and DRAIN.
- Session history: boot/chr-only sessions leave CART_SIZE and CART_SIZE_VALID untouched.
- ERR clears only on RES.

Optional Feature:
- Macro: ROMINIT_CART_CHECKSUM_EN.
- Defined: adds output CART_SUM [15:0], the mod-2^16 sum of all cart bytes written to the FIFO in the last cart session.
  - Cleared at LOAD entry.
  - Valid when CART_SIZE_VALID=1.
- Undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Boot load: stream 4096 bytes (data = addr[7:0]) with SEL_BOOT -> 4096 BOOT_WE pulses, each 1 cycle after VALID, final BOOT_A=0xFFF D=0xFF; CHR_WE and CART_REQ stay 0.
- Cart with 2-cycle ACK latency: 8 bytes at 1/cycle, FIFO_DEPTH=4.
  - Expect ERR=1 and fewer than 8 acked writes, with no A/D change while REQ is held.
  - Rerun with stream gaps of 3 cycles -> all 8 written in order, ERR=0.
- Cart size: 0x8000 bytes with immediate ACK -> after DONE, CART_SIZE=0x08000 and CART_SIZE_VALID=1. A subsequent CHR session leaves both unchanged.
- Out of range: SEL_CHR with ADDR=0x400 and 0x3FF -> only 0x3FF produces CHR_WE; ERR=0.
- Multiple selects: SEL_BOOT and SEL_CART both high for one byte -> BOOT_WE pulses, no cart push, ERR=1 until RES.
- Reset mid-drain: assert RES with 3 FIFO entries and REQ high -> REQ=0, BUSY=0, and ERR, CART_SIZE_VALID and all outputs at 0 the cycle after RES. With the checksum macro, cart bytes 0xFF x 300 -> CART_SUM=0x2AD4.
